// File: rtl/sdram_cmd_pkg.sv
// SDRAM command encodings and the read-engine state type, shared by the bank engines.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Command bits are {CS_N, RAS_N, CAS_N, WE_N}.
package sdram_cmd_pkg;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  // A10 high on PRE selects all banks.
  localparam logic [12:0] ADDR_PRE_ALL = 13'h0400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACT,
    S_READ,
    S_PRE
  } rd_state_t;

endpackage

// File: rtl/sdram_rd_capture.sv
// Read-data capture: turns each READ issue into BURST_LEN valid-qualified DQ samples.
// Latency: first rd_data_vld CAP_DLY cycles after the READ command cycle.
// Backpressure: none; the consumer must accept every valid word.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   rd_start     high during the cycle a READ command is on the bus
//   rd_dq        SDRAM DQ
//   rd_data      captured word, holds between bursts
//   rd_data_vld  high for BURST_LEN consecutive cycles per READ
// CAP_DLY must be at least 2.
module sdram_rd_capture #(
  parameter int CAP_DLY   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_start,
  input  logic [15:0] rd_dq,
  output logic [15:0] rd_data,
  output logic        rd_data_vld
);

  // The output register is the last stage of the delay, so the token pipe
  // is one shorter than CAP_DLY.
  localparam int PIPE = CAP_DLY - 1;
  localparam int BW   = $clog2(BURST_LEN + 1);

  logic [PIPE-1:0] dly;
  logic [BW-1:0]   left;
  logic            tap;

  assign tap = dly[PIPE-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      dly <= '0;
    end else begin
      dly[0] <= rd_start;
      for (int i = 1; i < PIPE; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  // A new token restarts the count, so back-to-back READs give an unbroken
  // valid stream with no gap between bursts.
  always_ff @(posedge clk) begin
    if (rst) begin
      left        <= '0;
      rd_data_vld <= 1'b0;
      rd_data     <= '0;
    end else if (tap) begin
      left        <= BW'(BURST_LEN - 1);
      rd_data_vld <= 1'b1;
      rd_data     <= rd_dq;
    end else if (left != '0) begin
      left        <= left - BW'(1);
      rd_data_vld <= 1'b1;
      rd_data     <= rd_dq;
    end else begin
      rd_data_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_read.sv
// Read bank engine: requests the bus, runs ACT/READ/PRE over RD_ROWS rows, streams read data.
// Latency: ACT one cycle after grant, first READ TRCD later, data CAP_DLY after each READ.
// Backpressure: yields the bus at burst boundaries on aref_req; data stream cannot be stalled.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   rd_trig       one-cycle job start, dropped while a job is open
//   aref_req      refresh pending, honoured at the next burst boundary
//   rd_en         arbiter grant pulse, honoured only while rd_req is high
//   rd_req        bus request
//   flag_rd_end   one-cycle pulse once the bank is precharged and the bus released
//   rd_cmd        {CS_N,RAS_N,CAS_N,WE_N}
//   rd_addr       SDRAM address
//   rd_dq         SDRAM DQ
//   rd_data       captured word, qualified by rd_data_vld
module sdram_read
  import sdram_cmd_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int COL_NUM   = 512,
  parameter int RD_ROWS   = 2,
  parameter int TRCD      = 2,
  parameter int TRP       = 2,
  parameter int CAP_DLY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_trig,
  input  logic        aref_req,
  input  logic        rd_en,
  output logic        rd_req,
  output logic        flag_rd_end,
  output logic [3:0]  rd_cmd,
  output logic [12:0] rd_addr,
  input  logic [15:0] rd_dq,
  output logic [15:0] rd_data,
  output logic        rd_data_vld
);

  localparam int CW = 8;

  rd_state_t     state;
  logic          job_open;
  logic [12:0]   row;
  logic [8:0]    col;
  logic [CW-1:0] cnt;

  logic [9:0]    col_sum;
  logic          col_wrap;
  logic [8:0]    col_nxt;

  // Column pointer after the current burst; one bit wider so the wrap
  // point is visible even when COL_NUM is a power of two.
  always_comb begin
    col_sum  = {1'b0, col} + 10'(BURST_LEN);
    col_wrap = (col_sum == 10'(COL_NUM));
    col_nxt  = col_wrap ? 9'd0 : col_sum[8:0];
  end

  // Outputs are registered, so each branch sets the command that will be
  // on the bus during the first cycle of the next state (or count).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      job_open    <= 1'b0;
      row         <= '0;
      col         <= '0;
      cnt         <= '0;
      rd_req      <= 1'b0;
      flag_rd_end <= 1'b0;
      rd_cmd      <= CMD_NOP;
      rd_addr     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          flag_rd_end <= 1'b0;
          rd_cmd      <= CMD_NOP;
          if (rd_trig && !job_open) begin
            job_open <= 1'b1;
            row      <= '0;
            col      <= '0;
          end
          if (rd_en && rd_req) begin
            state   <= S_ACT;
            rd_req  <= 1'b0;
            rd_cmd  <= CMD_ACT;
            rd_addr <= row;
            cnt     <= '0;
          end else begin
            rd_req <= job_open || rd_trig;
          end
        end

        // cnt counts cycles since the ACT cycle.
        S_ACT: begin
          if (cnt == CW'(TRCD - 1)) begin
            state   <= S_READ;
            rd_cmd  <= CMD_READ;
            rd_addr <= {4'b0, col};
            cnt     <= '0;
          end else begin
            rd_cmd <= CMD_NOP;
            cnt    <= cnt + CW'(1);
          end
        end

        // cnt is the burst position of the command currently on the bus.
        S_READ: begin
          if (cnt == CW'(BURST_LEN - 1)) begin
            col <= col_nxt;
            cnt <= '0;
            if (col_wrap) begin
              row <= row + 13'd1;
            end
            if (aref_req || col_wrap) begin
              state   <= S_PRE;
              rd_cmd  <= CMD_PRE;
              rd_addr <= ADDR_PRE_ALL;
            end else begin
              rd_cmd  <= CMD_READ;
              rd_addr <= {4'b0, col_nxt};
            end
          end else begin
            rd_cmd <= CMD_NOP;
            cnt    <= cnt + CW'(1);
          end
        end

        // cnt counts cycles since the PRE cycle; the job closes with the
        // end pulse once every row has been read.
        S_PRE: begin
          rd_cmd <= CMD_NOP;
          if (cnt == CW'(TRP - 1)) begin
            state       <= S_IDLE;
            flag_rd_end <= 1'b1;
            cnt         <= '0;
            if (row == 13'(RD_ROWS)) begin
              job_open <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  sdram_rd_capture #(
    .CAP_DLY   (CAP_DLY),
    .BURST_LEN (BURST_LEN)
  ) u_capture (
    .clk         (clk),
    .rst         (rst),
    .rd_start    (rd_cmd == CMD_READ),
    .rd_dq       (rd_dq),
    .rd_data     (rd_data),
    .rd_data_vld (rd_data_vld)
  );

endmodule
